// File: rtl/eco32f_decode.sv
// rtl/eco32f_decode.sv - eco32f ID-stage decoder and ID/EX pipeline register (optional ECO32F_DECODE_ILLEGAL_EN)
module eco32f_decode #(
    parameter int LINK_REG = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_stall,
    input  logic        id_flush,
    input  logic [31:0] id_insn,
    output logic [4:0]  id_rfa_adr,
    output logic [4:0]  id_rfb_adr,
    output logic        ex_op_add,
    output logic        ex_op_sub,
    output logic        ex_op_mul,
    output logic        ex_op_div,
    output logic        ex_op_rem,
    output logic        ex_op_or,
    output logic        ex_op_and,
    output logic        ex_op_xor,
    output logic        ex_op_xnor,
    output logic        ex_op_sll,
    output logic        ex_op_slr,
    output logic        ex_op_sar,
    output logic        ex_op_beq,
    output logic        ex_op_bne,
    output logic        ex_op_ble,
    output logic        ex_op_bleu,
    output logic        ex_op_blt,
    output logic        ex_op_bltu,
    output logic        ex_op_bge,
    output logic        ex_op_bgeu,
    output logic        ex_op_bgt,
    output logic        ex_op_bgtu,
    output logic        ex_op_jal,
    output logic        ex_op_j,
    output logic        ex_op_jr,
    output logic        ex_op_load,
    output logic        ex_op_store,
    output logic [1:0]  ex_lsu_len,
    output logic        ex_lsu_zext,
    output logic        ex_signed_div,
    output logic [31:0] ex_imm,
    output logic        ex_imm_sel,
    output logic [4:0]  ex_rd_adr,
    output logic        ex_rf_wb,
    output logic        ex_valid
`ifdef ECO32F_DECODE_ILLEGAL_EN
    ,
    output logic        ex_illegal
`endif
);

    // One-hot strobe masks; bit order matches the ex_ops unpacking below.
    localparam logic [26:0] M_ADD   = 27'd1 << 0;
    localparam logic [26:0] M_SUB   = 27'd1 << 1;
    localparam logic [26:0] M_MUL   = 27'd1 << 2;
    localparam logic [26:0] M_DIV   = 27'd1 << 3;
    localparam logic [26:0] M_REM   = 27'd1 << 4;
    localparam logic [26:0] M_OR    = 27'd1 << 5;
    localparam logic [26:0] M_AND   = 27'd1 << 6;
    localparam logic [26:0] M_XOR   = 27'd1 << 7;
    localparam logic [26:0] M_XNOR  = 27'd1 << 8;
    localparam logic [26:0] M_SLL   = 27'd1 << 9;
    localparam logic [26:0] M_SLR   = 27'd1 << 10;
    localparam logic [26:0] M_SAR   = 27'd1 << 11;
    localparam logic [26:0] M_BEQ   = 27'd1 << 12;
    localparam logic [26:0] M_JAL   = 27'd1 << 22;
    localparam logic [26:0] M_J     = 27'd1 << 23;
    localparam logic [26:0] M_JR    = 27'd1 << 24;
    localparam logic [26:0] M_LOAD  = 27'd1 << 25;
    localparam logic [26:0] M_STORE = 27'd1 << 26;
    localparam logic [4:0]  LINK_ADR = 5'(LINK_REG);

    logic [5:0]  op;
    logic [15:0] imm16;
    logic [31:0] sx16;
    logic [31:0] zx16;
    logic [26:0] d_ops;
    logic [31:0] d_imm;
    logic        d_imm_sel;
    logic [4:0]  d_rd;
    logic        d_wb_raw;
    logic        d_wb;
    logic [1:0]  d_len;
    logic        d_zext;
    logic        d_sdiv;
    logic [26:0] ex_ops;
`ifdef ECO32F_DECODE_ILLEGAL_EN
    logic        d_ill;
`endif

    assign op         = id_insn[31:26];
    assign imm16      = id_insn[15:0];
    assign sx16       = {{16{imm16[15]}}, imm16};
    assign zx16       = {16'h0000, imm16};
    assign id_rfb_adr = id_insn[20:16];
    // r0 is never a valid destination, so writes to it are dropped here
    assign d_wb       = d_wb_raw && (d_rd != 5'd0);

    // Combinational decode of the instruction sitting in ID.
    always_comb begin
        d_ops      = '0;
        d_imm      = '0;
        d_imm_sel  = 1'b0;
        d_rd       = '0;
        d_wb_raw   = 1'b0;
        d_len      = 2'd0;
        d_zext     = 1'b0;
        d_sdiv     = 1'b0;
        id_rfa_adr = id_insn[25:21];
`ifdef ECO32F_DECODE_ILLEGAL_EN
        d_ill      = 1'b0;
`endif
        if (op <= 6'h1D) begin
            // Paired ALU ops: even = register form, odd = immediate form into ry
            d_wb_raw  = 1'b1;
            d_imm_sel = op[0];
            d_rd      = op[0] ? id_insn[20:16] : id_insn[15:11];
            // Unsigned arithmetic (07/0B/0F), logic and shifts zero-extend
            if (op[0])
                d_imm = (op[4] || (op[1] && (op[3] || op[2]))) ? zx16 : sx16;
            d_sdiv = (op[4:1] == 4'd4) || (op[4:1] == 4'd6);
            case (op[4:1])
                4'd0:    d_ops = M_ADD;
                4'd1:    d_ops = M_SUB;
                4'd2:    d_ops = M_MUL;
                4'd3:    d_ops = M_MUL;
                4'd4:    d_ops = M_DIV;
                4'd5:    d_ops = M_DIV;
                4'd6:    d_ops = M_REM;
                4'd7:    d_ops = M_REM;
                4'd8:    d_ops = M_AND;
                4'd9:    d_ops = M_OR;
                4'd10:   d_ops = M_XOR;
                4'd11:   d_ops = M_XNOR;
                4'd12:   d_ops = M_SLL;
                4'd13:   d_ops = M_SLR;
                default: d_ops = M_SAR;
            endcase
        end else if (op == 6'h1F) begin
            // ldhi is r0 + (imm16 << 16)
            d_ops      = M_ADD;
            d_imm      = {imm16, 16'h0000};
            d_imm_sel  = 1'b1;
            d_rd       = id_insn[20:16];
            d_wb_raw   = 1'b1;
            id_rfa_adr = 5'd0;
        end else if (op >= 6'h20 && op <= 6'h29) begin
            // Branch strobes are laid out in opcode order starting at beq
            d_ops = M_BEQ << op[3:0];
            d_imm = {sx16[29:0], 2'b00};
        end else if (op >= 6'h2A && op <= 6'h2D) begin
            if (!op[0])
                d_imm = {{4{id_insn[25]}}, id_insn[25:0], 2'b00};
            d_ops = op[0] ? M_JR : M_J;
            if (op[2]) begin
                d_ops    = d_ops | M_JAL;
                d_rd     = LINK_ADR;
                d_wb_raw = 1'b1;
            end
        end else if (op >= 6'h30 && op <= 6'h37) begin
            d_imm     = sx16;
            d_imm_sel = 1'b1;
            case (op[2:0])
                3'd0:    begin d_len = 2'd2; end
                3'd1:    begin d_len = 2'd1; end
                3'd2:    begin d_len = 2'd1; d_zext = 1'b1; end
                3'd3:    begin d_len = 2'd0; end
                3'd4:    begin d_len = 2'd0; d_zext = 1'b1; end
                3'd5:    begin d_len = 2'd2; end
                3'd6:    begin d_len = 2'd1; end
                default: begin d_len = 2'd0; end
            endcase
            if (op[2:0] <= 3'd4) begin
                d_ops    = M_ADD | M_LOAD;
                d_rd     = id_insn[20:16];
                d_wb_raw = 1'b1;
            end else begin
                d_ops = M_ADD | M_STORE;
            end
        end
`ifdef ECO32F_DECODE_ILLEGAL_EN
        else if (op == 6'h1E || op >= 6'h3B) begin
            d_ill = 1'b1;
        end
`endif
    end

    // ID/EX register: ex_stall holds, flush/id_stall inject a bubble keeping data fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_ops        <= '0;
            ex_imm        <= '0;
            ex_imm_sel    <= 1'b0;
            ex_rd_adr     <= '0;
            ex_rf_wb      <= 1'b0;
            ex_lsu_len    <= 2'd0;
            ex_lsu_zext   <= 1'b0;
            ex_signed_div <= 1'b0;
            ex_valid      <= 1'b0;
        end else if (!ex_stall) begin
            if (id_flush || id_stall) begin
                ex_ops   <= '0;
                ex_rf_wb <= 1'b0;
                ex_valid <= 1'b0;
            end else begin
                ex_ops        <= d_ops;
                ex_imm        <= d_imm;
                ex_imm_sel    <= d_imm_sel;
                ex_rd_adr     <= d_rd;
                ex_rf_wb      <= d_wb;
                ex_lsu_len    <= d_len;
                ex_lsu_zext   <= d_zext;
                ex_signed_div <= d_sdiv;
                ex_valid      <= 1'b1;
            end
        end
    end

`ifdef ECO32F_DECODE_ILLEGAL_EN
    // Illegal-opcode flag follows the same hold/bubble rules as the strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ex_illegal <= 1'b0;
        else if (!ex_stall)
            ex_illegal <= (id_flush || id_stall) ? 1'b0 : d_ill;
    end
`endif

    assign {ex_op_store, ex_op_load, ex_op_jr, ex_op_j, ex_op_jal,
            ex_op_bgtu, ex_op_bgt, ex_op_bgeu, ex_op_bge, ex_op_bltu,
            ex_op_blt, ex_op_bleu, ex_op_ble, ex_op_bne, ex_op_beq,
            ex_op_sar, ex_op_slr, ex_op_sll, ex_op_xnor, ex_op_xor,
            ex_op_and, ex_op_or, ex_op_rem, ex_op_div, ex_op_mul,
            ex_op_sub, ex_op_add} = ex_ops;

endmodule

// File: tb/tb_eco32f_decode.sv
// tb/tb_eco32f_decode.sv - scoreboard bench for eco32f_decode
module tb_eco32f_decode;

    localparam logic [26:0] P_ADD   = 27'd1 << 0;
    localparam logic [26:0] P_MUL   = 27'd1 << 2;
    localparam logic [26:0] P_DIV   = 27'd1 << 3;
    localparam logic [26:0] P_REM   = 27'd1 << 4;
    localparam logic [26:0] P_OR    = 27'd1 << 5;
    localparam logic [26:0] P_XNOR  = 27'd1 << 8;
    localparam logic [26:0] P_SAR   = 27'd1 << 11;
    localparam logic [26:0] P_BEQ   = 27'd1 << 12;
    localparam logic [26:0] P_BGTU  = 27'd1 << 21;
    localparam logic [26:0] P_JAL   = 27'd1 << 22;
    localparam logic [26:0] P_J     = 27'd1 << 23;
    localparam logic [26:0] P_JR    = 27'd1 << 24;
    localparam logic [26:0] P_LOAD  = 27'd1 << 25;
    localparam logic [26:0] P_STORE = 27'd1 << 26;

    typedef struct {
        logic        valid;
        logic [26:0] ops;
        logic [31:0] imm;
        logic        sel;
        logic [4:0]  rd;
        logic        wb;
        logic [1:0]  len;
        logic        zext;
        logic        sdiv;
        logic        ill;
        logic [4:0]  rfa;
        logic [4:0]  rfb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_stall = 1'b0;
    logic        ex_stall = 1'b0;
    logic        id_flush = 1'b0;
    logic [31:0] id_insn = 32'h0423FFFF;
    logic [4:0]  id_rfa_adr, id_rfb_adr;
    logic ex_op_add, ex_op_sub, ex_op_mul, ex_op_div, ex_op_rem, ex_op_or, ex_op_and;
    logic ex_op_xor, ex_op_xnor, ex_op_sll, ex_op_slr, ex_op_sar;
    logic ex_op_beq, ex_op_bne, ex_op_ble, ex_op_bleu, ex_op_blt, ex_op_bltu;
    logic ex_op_bge, ex_op_bgeu, ex_op_bgt, ex_op_bgtu;
    logic ex_op_jal, ex_op_j, ex_op_jr, ex_op_load, ex_op_store;
    logic [1:0]  ex_lsu_len;
    logic        ex_lsu_zext, ex_signed_div, ex_imm_sel, ex_rf_wb, ex_valid;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd_adr;
    logic        ill_act;
    logic [26:0] act_ops;

    int total = 0;
    int bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    eco32f_decode dut (
        .clk(clk), .rst(rst), .id_stall(id_stall), .ex_stall(ex_stall),
        .id_flush(id_flush), .id_insn(id_insn),
        .id_rfa_adr(id_rfa_adr), .id_rfb_adr(id_rfb_adr),
        .ex_op_add(ex_op_add), .ex_op_sub(ex_op_sub), .ex_op_mul(ex_op_mul),
        .ex_op_div(ex_op_div), .ex_op_rem(ex_op_rem), .ex_op_or(ex_op_or),
        .ex_op_and(ex_op_and), .ex_op_xor(ex_op_xor), .ex_op_xnor(ex_op_xnor),
        .ex_op_sll(ex_op_sll), .ex_op_slr(ex_op_slr), .ex_op_sar(ex_op_sar),
        .ex_op_beq(ex_op_beq), .ex_op_bne(ex_op_bne), .ex_op_ble(ex_op_ble),
        .ex_op_bleu(ex_op_bleu), .ex_op_blt(ex_op_blt), .ex_op_bltu(ex_op_bltu),
        .ex_op_bge(ex_op_bge), .ex_op_bgeu(ex_op_bgeu), .ex_op_bgt(ex_op_bgt),
        .ex_op_bgtu(ex_op_bgtu), .ex_op_jal(ex_op_jal), .ex_op_j(ex_op_j),
        .ex_op_jr(ex_op_jr), .ex_op_load(ex_op_load), .ex_op_store(ex_op_store),
        .ex_lsu_len(ex_lsu_len), .ex_lsu_zext(ex_lsu_zext),
        .ex_signed_div(ex_signed_div), .ex_imm(ex_imm), .ex_imm_sel(ex_imm_sel),
        .ex_rd_adr(ex_rd_adr), .ex_rf_wb(ex_rf_wb), .ex_valid(ex_valid)
`ifdef ECO32F_DECODE_ILLEGAL_EN
        , .ex_illegal(ill_act)
`endif
    );

`ifndef ECO32F_DECODE_ILLEGAL_EN
    assign ill_act = 1'b0;
`endif

    assign act_ops = {ex_op_store, ex_op_load, ex_op_jr, ex_op_j, ex_op_jal,
                      ex_op_bgtu, ex_op_bgt, ex_op_bgeu, ex_op_bge, ex_op_bltu,
                      ex_op_blt, ex_op_bleu, ex_op_ble, ex_op_bne, ex_op_beq,
                      ex_op_sar, ex_op_slr, ex_op_sll, ex_op_xnor, ex_op_xor,
                      ex_op_and, ex_op_or, ex_op_rem, ex_op_div, ex_op_mul,
                      ex_op_sub, ex_op_add};

    function automatic exp_t mk(input logic v, input logic [26:0] o, input logic [31:0] i,
                                input logic s, input logic [4:0] r, input logic w,
                                input logic [1:0] l, input logic z, input logic d,
                                input logic il, input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        e.valid = v; e.ops = o; e.imm = i; e.sel = s; e.rd = r; e.wb = w;
        e.len = l; e.zext = z; e.sdiv = d; e.ill = il; e.rfa = a; e.rfb = b;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs at negedge and queue what EX must show after the next posedge.
    task automatic step(input logic r, input logic [31:0] insn, input logic ids,
                        input logic exs, input logic fl, input exp_t e);
        @(negedge clk);
        rst = r; id_insn = insn; id_stall = ids; ex_stall = exs; id_flush = fl;
        q.push_back(e);
    endtask

    // Monitor: compare after each active edge whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid", 32'(ex_valid), 32'(e.valid));
                chk("ops", 32'(act_ops), 32'(e.ops));
                chk("imm", ex_imm, e.imm);
                chk("imm_sel", 32'(ex_imm_sel), 32'(e.sel));
                chk("rd", 32'(ex_rd_adr), 32'(e.rd));
                chk("rf_wb", 32'(ex_rf_wb), 32'(e.wb));
                chk("lsu_len", 32'(ex_lsu_len), 32'(e.len));
                chk("lsu_zext", 32'(ex_lsu_zext), 32'(e.zext));
                chk("sdiv", 32'(ex_signed_div), 32'(e.sdiv));
                chk("rfa", 32'(id_rfa_adr), 32'(e.rfa));
                chk("rfb", 32'(id_rfb_adr), 32'(e.rfb));
`ifdef ECO32F_DECODE_ILLEGAL_EN
                chk("illegal", 32'(ill_act), 32'(e.ill));
`endif
            end
        end
    end

    initial begin
        exp_t z, e_addi, e_ori, e_r0;
        z      = mk(0, 27'd0, 32'h0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 5'd1, 5'd3);
        e_addi = mk(1, P_ADD, 32'h00000007, 1, 5'd2, 1, 2'd0, 0, 0, 0, 5'd1, 5'd2);
        e_ori  = mk(1, P_OR, 32'h00008000, 1, 5'd2, 1, 2'd0, 0, 0, 0, 5'd1, 5'd2);
        e_r0   = mk(1, P_ADD, 32'h00000005, 1, 5'd0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd0);

        step(0, 32'h0423FFFF, 0, 0, 0, z);
        step(1, 32'h0423FFFF, 0, 0, 0, mk(1, P_ADD, 32'hFFFFFFFF, 1, 5'd3, 1, 2'd0, 0, 0, 0, 5'd1, 5'd3));
        step(1, 32'h4C228000, 0, 0, 0, e_ori);
        step(1, 32'h20221800, 0, 0, 0, mk(1, P_DIV, 32'h0, 0, 5'd3, 1, 2'd0, 0, 1, 0, 5'd1, 5'd2));
        step(1, 32'h8022FFFF, 0, 0, 0, mk(1, P_BEQ, 32'hFFFFFFFC, 0, 5'd0, 0, 2'd0, 0, 0, 0, 5'd1, 5'd2));
        step(1, 32'hB0000001, 0, 0, 0, mk(1, P_JAL | P_J, 32'h4, 0, 5'd31, 1, 2'd0, 0, 0, 0, 5'd0, 5'd0));
        step(1, 32'hB4200000, 0, 0, 0, mk(1, P_JAL | P_JR, 32'h0, 0, 5'd31, 1, 2'd0, 0, 0, 0, 5'd1, 5'd0));
        step(1, 32'hC845FFF0, 0, 0, 0, mk(1, P_ADD | P_LOAD, 32'hFFFFFFF0, 1, 5'd5, 1, 2'd1, 1, 0, 0, 5'd2, 5'd5));
        step(1, 32'hDC640010, 0, 0, 0, mk(1, P_ADD | P_STORE, 32'h10, 1, 5'd0, 0, 2'd0, 0, 0, 0, 5'd3, 5'd4));
        step(1, 32'h7CE61234, 0, 0, 0, mk(1, P_ADD, 32'h12340000, 1, 5'd6, 1, 2'd0, 0, 0, 0, 5'd0, 5'd6));
        step(1, 32'h58224800, 0, 0, 0, mk(1, P_XNOR, 32'h0, 0, 5'd9, 1, 2'd0, 0, 0, 0, 5'd1, 5'd2));
        step(1, 32'h74248003, 0, 0, 0, mk(1, P_SAR, 32'h00008003, 1, 5'd4, 1, 2'd0, 0, 0, 0, 5'd1, 5'd4));
        step(1, 32'h1C22FFFF, 0, 0, 0, mk(1, P_MUL, 32'h0000FFFF, 1, 5'd2, 1, 2'd0, 0, 0, 0, 5'd1, 5'd2));
        step(1, 32'h3422FFFE, 0, 0, 0, mk(1, P_REM, 32'hFFFFFFFE, 1, 5'd2, 1, 2'd0, 0, 1, 0, 5'd1, 5'd2));
        step(1, 32'hA4220001, 0, 0, 0, mk(1, P_BGTU, 32'h4, 0, 5'd0, 0, 2'd0, 0, 0, 0, 5'd1, 5'd2));

        // ex_stall holds the ADDI for three cycles while ID shows ORI
        step(1, 32'h04220007, 0, 0, 0, e_addi);
        for (int i = 0; i < 3; i++) step(1, 32'h4C228000, 0, 1, 0, e_addi);
        step(1, 32'h4C228000, 0, 0, 0, e_ori);

        // Flush and id_stall bubbles keep the ORI data fields
        step(1, 32'h00221800, 0, 0, 1, mk(0, 27'd0, 32'h00008000, 1, 5'd2, 0, 2'd0, 0, 0, 0, 5'd1, 5'd2));
        step(1, 32'h00221800, 1, 0, 0, mk(0, 27'd0, 32'h00008000, 1, 5'd2, 0, 2'd0, 0, 0, 0, 5'd1, 5'd2));
        step(1, 32'h00221800, 0, 0, 0, mk(1, P_ADD, 32'h0, 0, 5'd3, 1, 2'd0, 0, 0, 0, 5'd1, 5'd2));
        step(1, 32'h04000005, 0, 0, 0, e_r0);
        // ex_stall beats id_flush
        e_r0.rfa = 5'd1; e_r0.rfb = 5'd2;
        step(1, 32'h4C228000, 0, 1, 1, e_r0);

        step(1, 32'hB8000000, 0, 0, 0, mk(1, 27'd0, 32'h0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 5'd0, 5'd0));
        step(1, 32'hFC000000, 0, 0, 0, mk(1, 27'd0, 32'h0, 0, 5'd0, 0, 2'd0, 0, 0, 1, 5'd0, 5'd0));

        // Reset while stalled clears EX; first clean cycle after reset loads
        step(1, 32'h04220007, 0, 0, 0, e_addi);
        z.rfa = 5'd1; z.rfb = 5'd2;
        step(0, 32'h4C228000, 0, 1, 0, z);
        step(1, 32'h4C228000, 0, 0, 0, e_ori);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            bad++;
            total++;
            $display("FAIL drain act=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eco32f_decode.md
Name: eco32f_decode

Overview:
- Instruction decode stage and ID/EX pipeline register of the eco32f core.
- Drives the one-hot operation strobes, operand selects and immediates that the EX-stage ALU, divider and multiplier consume.
- Decodes the instruction word in ID combinationally, then registers the result into EX under the pipeline's stall and flush rules.
- Also produces the register-file read addresses combinationally.

Parameters:
- LINK_REG, 31, destination register written by jal/jalr.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-low reset.
- id_stall  input  1  ID stage stalled; EX receives a bubble.
- ex_stall  input  1  EX stage stalled; ID/EX register holds.
- id_flush  input  1  squash the instruction entering EX.
- id_insn  input  32  instruction word in ID.
- id_rfa_adr  output  5  combinational rx = id_insn[25:21].
- id_rfb_adr  output  5  combinational ry = id_insn[20:16].
- ex_op_add, ex_op_sub, ex_op_mul, ex_op_div, ex_op_rem, ex_op_or, ex_op_and, ex_op_xor, ex_op_xnor, ex_op_sll, ex_op_slr, ex_op_sar  output  1 each  ALU operation strobes.
- ex_op_beq, ex_op_bne, ex_op_ble, ex_op_bleu, ex_op_blt, ex_op_bltu, ex_op_bge, ex_op_bgeu, ex_op_bgt, ex_op_bgtu  output  1 each  branch strobes.
- ex_op_jal  output  1  jal or jalr; result is the link address.
- ex_op_j  output  1  j or jal.
- ex_op_jr  output  1  jr or jalr.
- ex_op_load  output  1  ldw, ldh, ldhu, ldb, ldbu.
- ex_op_store  output  1  stw, sth, stb.
- ex_lsu_len  output  2  access size: 2=word, 1=half, 0=byte.
- ex_lsu_zext  output  1  zero-extend the load result.
- ex_signed_div  output  1  signed div/rem.
- ex_imm  output  32  extended immediate or branch/jump offset.
- ex_imm_sel  output  1  ALU y operand comes from ex_imm.
- ex_rd_adr  output  5  destination register.
- ex_rf_wb  output  1  instruction writes the register file.
- ex_valid  output  1  EX holds a real instruction (not a bubble).

Behaviour:
- Field layout: op = insn[31:26]. R-type destination is insn[15:11]. I-type destination is ry = insn[20:16].
- ALU opcodes 0x00–0x1D are paired: even = R-type, odd = immediate.
- Arithmetic opcode map:
  - add 00, sub 02: ex_op_add / ex_op_sub.
  - mul 04, mulu 06: ex_op_mul.
  - div 08, divu 0A: ex_op_div.
  - rem 0C, remu 0E: ex_op_rem.
  - ex_signed_div=1 for 08/09/0C/0D only.
- Logic and shift opcode map: and 10, or 12, xor 14, xnor 16, sll 18, slr 1A, sar 1C.
- ldhi 1F: ex_op_add with x=r0 (ex_rd_adr=ry, id_rfa_adr forced to 0); ex_imm = {imm16,16'h0}; ex_imm_sel=1.
- Immediate extension:
  - Sign-extended for add/sub/mul/div/rem signed forms.
  - Zero-extended for unsigned forms (07/0B/0F), logic ops and shifts.
- Branches 20–29, in order beq, bne, ble, bleu, blt, bltu, bge, bgeu, bgt, bgtu:
  - ex_imm = sext(imm16)<<2.
  - ex_imm_sel=0, ex_rf_wb=0.
- Jumps:
  - j 2A, jal 2C: ex_imm = sext(insn[25:0])<<2.
  - jr 2B, jalr 2D: target is rx.
  - jal/jalr: ex_rd_adr = LINK_REG, ex_rf_wb=1.
- Loads 30–34 (ldw, ldh, ldhu, ldb, ldbu) and stores 35–37 (stw, sth, stb):
  - ex_op_add computes the address; ex_imm = sext(imm16); ex_imm_sel=1.
  - Loads: ex_rf_wb=1. Stores: ex_rf_wb=0.
- Write-enable qualifier: ex_rf_wb is forced 0 when ex_rd_adr==0.
- Exactly one ex_op_* ALU/branch strobe is high per valid instruction. Exception: jal/jalr raise ex_op_jal together with ex_op_j or ex_op_jr.
- Unlisted opcodes (trap, rfx, mvfs, mvts, tbs, undefined) decode as a bubble with ex_valid=1 and all strobes 0.
- Register update on posedge clk, priority high to low:
  1. rst low → all outputs 0 asynchronously.
  2. ex_stall → hold every registered output.
  3. id_flush or id_stall → bubble: ex_valid, all strobes, ex_rf_wb = 0; data fields unchanged.
  4. Otherwise load the decoded instruction.
- Simultaneous ex_stall and id_flush: hold. The flush is the controller's responsibility to re-assert.
- Latency: one cycle from id_insn to ex_* outputs. id_rfa_adr/id_rfb_adr are zero-latency.
- Reset mid-stall: all outputs clear; the first post-reset cycle without stalls loads normally.

Optional Feature:
- ECO32F_DECODE_ILLEGAL_EN:
  - Adds output ex_illegal (1 bit, reset 0, registered with the same stall/flush rules).
  - Set for undefined opcodes 1E, 3B–3F; the instruction becomes a bubble with ex_valid=1.
- Without the macro: the port is absent and undefined opcodes are silent bubbles.

Test Plan:
- Reset low while id_insn=0x0423FFFF → all outputs 0. Release, one clk → ex_op_add=1, ex_imm=0xFFFFFFFF, ex_imm_sel=1, ex_rd_adr=3, ex_rf_wb=1, ex_valid=1.
- ORI 0x4C228000 → ex_op_or=1, ex_imm=0x00008000, ex_rd_adr=2. DIV r3=r1/r2 (0x20221800) → ex_op_div=1, ex_signed_div=1, ex_imm_sel=0, ex_rd_adr=3.
- BEQ 0x8022FFFF → ex_op_beq=1, ex_imm=0xFFFFFFFC, ex_rf_wb=0. JAL offset 1 (0xB0000001) → ex_op_jal=1, ex_op_j=1, ex_imm=4, ex_rd_adr=31, ex_rf_wb=1.
- Load ADDI, then ex_stall=1 for 3 cycles with new id_insn → outputs unchanged. Release → new instruction appears next cycle.
- id_flush=1 (or id_stall=1) with valid ADD → ex_valid=0, ex_op_add=0, ex_rf_wb=0. ADDI to r0 (0x0400_0005) → ex_rf_wb=0.
- With ECO32F_DECODE_ILLEGAL_EN, insn 0xFC000000 → ex_illegal=1, all strobes 0. Without the macro, same insn → bubble, no ex_illegal port.
